// File: rtl/char_buf_text.sv
// char_buf_text: writable COLS x ROWS character grid with a registered read port, cursor or explicit writes, and a self-clearing FSM.
// Ports: clk, rst (async, active-high); char_xy -> char_code_out (1-cycle registered read, {row,col});
//        wr_valid/wr_ready handshake with wr_cursor, wr_xy, wr_code; clr_req starts a clear;
//        busy is high while clearing; cursor_xy is the current cursor {row,col}.
module char_buf_text #(
    parameter int                COL_W     = 4,
    parameter int                ROW_W     = 4,
    parameter int                CODE_W    = 7,
    parameter logic [CODE_W-1:0] FILL_CODE = 7'h20,
    parameter logic [CODE_W-1:0] NL_CODE   = 7'h0A
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W+COL_W-1:0] char_xy,
    output logic [CODE_W-1:0]      char_code_out,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_cursor,
    input  logic [ROW_W+COL_W-1:0] wr_xy,
    input  logic [CODE_W-1:0]      wr_code,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [ROW_W+COL_W-1:0] cursor_xy
);
    localparam int AW = ROW_W + COL_W;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]     cursor_q, cursor_d;
    logic [CODE_W-1:0] rd_q;
    logic [CODE_W-1:0] mem [2**AW];
    logic              acc, nl, we;
    logic [AW-1:0]     wa;
    logic [CODE_W-1:0] wd;

    assign wr_ready      = state_q == S_IDLE && !clr_req;
    assign busy          = state_q == S_CLEAR;
    assign cursor_xy     = cursor_q;
    assign char_code_out = rd_q;

    always_comb begin
        acc       = wr_valid && wr_ready;
        nl        = wr_cursor && wr_code == NL_CODE;
        we        = state_q == S_CLEAR || (acc && !nl);
        wa        = state_q == S_CLEAR ? clr_cnt_q : wr_cursor ? cursor_q : wr_xy;
        wd        = state_q == S_CLEAR ? FILL_CODE : wr_code;
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (&clr_cnt_q)
                state_d = S_IDLE;
        end else if (clr_req) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
            cursor_d  = '0;
        end else if (acc && wr_cursor) begin
            // A plain +1 on {row,col} already carries col overflow into row and wraps the last cell to 0.
            cursor_d = nl ? {cursor_q[AW-1:COL_W] + ROW_W'(1), COL_W'(0)} : cursor_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            cursor_q  <= '0;
            rd_q      <= FILL_CODE;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cursor_q  <= cursor_d;
            rd_q      <= state_q == S_CLEAR ? FILL_CODE : mem[char_xy];
        end
    end

    // Array is not reset; the clear FSM initialises it. Read above samples the old value (read-first).
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end
endmodule

// File: tb/tb_char_buf_text.sv
// tb_char_buf_text: directed self-checking bench for char_buf_text at default parameters.
module tb_char_buf_text;
    logic       clk = 0, rst = 0;
    logic [7:0] char_xy = 0, wr_xy = 0, cursor_xy;
    logic [6:0] char_code_out, wr_code = 0, d;
    logic       wr_valid = 0, wr_ready, wr_cursor = 0, clr_req = 0, busy;
    logic [6:0] exp_mem [256];
    logic [7:0] mcur = 0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    char_buf_text dut (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_code_out(char_code_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_cursor(wr_cursor), .wr_xy(wr_xy),
        .wr_code(wr_code), .clr_req(clr_req), .busy(busy), .cursor_xy(cursor_xy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int n = 0, bad = 0;
        while (busy && n < 1000) begin
            tick;
            n++;
            if (char_code_out !== 7'h20) bad++;
        end
        chk({tag, "_len"}, n, 256);
        chk({tag, "_rd"}, bad, 0);
        for (int a = 0; a < 256; a++) exp_mem[a] = 7'h20;
        mcur = 0;
    endtask

    task automatic wr(input logic cur, input logic [7:0] xy, input logic [6:0] code);
        wr_valid = 1; wr_cursor = cur; wr_xy = xy; wr_code = code;
        #1;
        chk("wr_ready", wr_ready, 1);
        tick;
        wr_valid = 0;
        if (!cur) exp_mem[xy] = code;
        else if (code == 7'h0A) mcur = {mcur[7:4] + 4'd1, 4'd0};
        else begin
            exp_mem[mcur] = code;
            mcur = mcur + 8'd1;
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [6:0] q);
        char_xy = a;
        tick;
        q = char_code_out;
    endtask

    task automatic sweep(input string tag);
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            char_xy = 8'(a);
            tick;
            if (char_code_out !== exp_mem[a]) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #2 rst = 1;
        #1;
        chk("rst_rd", char_code_out, 7'h20);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_curs", cursor_xy, 0);
        repeat (3) tick;
        rst = 0;
        wait_clear("boot");
        sweep("boot_sweep");

        wr(0, 8'hC3, 7'h49);
        chk("curs_expl", cursor_xy, 8'h00);
        rd(8'hC3, d); chk("rd_C3", d, 7'h49);

        for (int i = 0; i < 14; i++) wr(1, 0, 7'(7'h30 + i));
        chk("curs_0E", cursor_xy, 8'h0E);
        wr(1, 0, 7'h57); wr(1, 0, 7'h41); wr(1, 0, 7'h49); wr(1, 0, 7'h54);
        chk("curs_12", cursor_xy, 8'h12);
        wr(1, 0, 7'h0A);
        chk("curs_nl", cursor_xy, 8'h20);
        rd(8'h0E, d); chk("rd_0E", d, 7'h57);
        rd(8'h0F, d); chk("rd_0F", d, 7'h41);
        rd(8'h10, d); chk("rd_10", d, 7'h49);
        rd(8'h11, d); chk("rd_11", d, 7'h54);
        rd(8'h12, d); chk("rd_12", d, 7'h20);

        for (int i = 0; i < 13; i++) wr(1, 0, 7'h0A);
        chk("curs_F0", cursor_xy, 8'hF0);
        for (int i = 0; i < 15; i++) wr(1, 0, 7'(7'h41 + i));
        chk("curs_FF", cursor_xy, 8'hFF);
        wr(1, 0, 7'h18);
        chk("curs_wrap", cursor_xy, 8'h00);
        rd(8'hFF, d); chk("rd_FF", d, 7'h18);
        for (int i = 0; i < 15; i++) wr(1, 0, 7'h0A);
        chk("curs_nl_F0", cursor_xy, 8'hF0);
        wr(1, 0, 7'h0A);
        chk("curs_nl_wrap", cursor_xy, 8'h00);
        sweep("grid_sweep");

        wr(1, 0, 7'h21);
        chk("curs_01", cursor_xy, 8'h01);
        char_xy = 8'hC3;
        wr_valid = 1; wr_cursor = 0; wr_xy = 8'h05; wr_code = 7'h33; clr_req = 1;
        #1;
        chk("ready_clr", wr_ready, 0);
        tick;
        clr_req = 0; wr_valid = 0;
        chk("busy_rise", busy, 1);
        chk("curs_clr", cursor_xy, 0);
        wait_clear("clr");
        sweep("clr_sweep");

        clr_req = 1;
        tick;
        clr_req = 0;
        repeat (100) tick;
        chk("mid_busy", busy, 1);
        rst = 1;
        #1;
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_rd", char_code_out, 7'h20);
        tick;
        rst = 0;
        wait_clear("rst_mid");

        wr(1, 0, 7'h41);
        chk("curs_A", cursor_xy, 8'h01);
        wr_valid = 1; wr_cursor = 1; wr_code = 7'h42;
        rst = 1;
        #1;
        chk("wr_rst_curs", cursor_xy, 0);
        chk("wr_rst_ready", wr_ready, 0);
        tick;
        rst = 0; wr_valid = 0;
        wait_clear("rst_wr");
        sweep("rst_sweep");

        wr_valid = 1; wr_cursor = 0; wr_xy = 8'h40; wr_code = 7'h55; char_xy = 8'h40;
        tick;
        wr_valid = 0;
        chk("rfw_old", char_code_out, 7'h20);
        tick;
        chk("rfw_new", char_code_out, 7'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
